mux_unstriping: RTL and testbench
=================================

Name: mux_unstriping

Overview:
- Receive-side counterpart of the two-lane striping stage: it merges two lanes back into one word stream.
- Each lane delivers words with its own valid; the lanes can be skewed by a few cycles.
- Each lane has a small FIFO to absorb that skew.
- Words are read out strictly alternating, starting with lane 0, so the original word order is restored.
- Sits between the lane receivers and the single-stream consumer, in the clk_2f domain.

Parameters:
- WIDTH, 32, word width of the lanes and the output.
- DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2.

Ports:
- clk_2f  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in0  in  WIDTH  lane 0 word.
- valid_in0  in  1  lane 0 word is valid this cycle.
- data_in1  in  WIDTH  lane 1 word.
- valid_in1  in  1  lane 1 word is valid this cycle.
- data_out  out  WIDTH  merged word, registered.
- valid_out  out  1  data_out holds a new word this cycle, registered.
- overflow_err  out  1  sticky flag: a word was dropped because its lane FIFO was full.
- lane_sel  out  1  lane that will be read next (current selector).

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - data_out=0, valid_out=0, overflow_err=0, lane_sel=0.
  - Both FIFO pointers and counts are cleared.
  - Reset asserted mid-stream discards all buffered words immediately.
  - After release, the first word read comes from lane 0.
- Write side (per lane, independent):
  - valid_inX=1 on an edge pushes data_inX into FIFO X.
  - Words with valid_inX=0 are ignored.
- Full FIFO:
  - Push while full and no pop on that lane in the same cycle: the word is dropped, the FIFO is unchanged, overflow_err is set.
  - overflow_err stays set until reset.
  - Push and pop on the same full FIFO in the same cycle: both succeed, count unchanged, no error.
- Read side, each edge:
  - If FIFO[lane_sel] is non-empty: pop its head into data_out, set valid_out=1, toggle lane_sel.
  - If FIFO[lane_sel] is empty: valid_out=0, data_out holds its previous value, lane_sel holds.
  - The selector never skips a lane. If lane 1 has data but lane 0 is selected and empty, the block waits.
- Latency:
  - No write-to-output bypass.
  - A word pushed at edge N can be popped at edge N+1 at the earliest. It is then visible on data_out after edge N+1, so minimum latency is 1 cycle.
- Push on an empty FIFO in the same cycle the selector looks at it: no pop that cycle; the word pops on the next edge.
- Pointers:
  - log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - Count is held in a log2(DEPTH)+1 bit register.
  - full = (count==DEPTH), empty = (count==0).
- Throughput: one word per cycle sustained when both lanes keep their FIFOs non-empty.

Test Plan:
- Reset then aligned input: lane0 gets A0,A1 and lane1 gets B0,B1 on the same cycles (all valid), starting at cycle 1 -> data_out=A0,B0,A1,B1 with valid_out=1 on cycles 2..5; lane_sel ends at 0.
- Skew: lane0 sends 0x11 at cycle 1; lane1 sends 0x22 at cycle 4 -> 0x11 out at cycle 2, valid_out=0 on cycles 3-4, 0x22 out at cycle 5.
- Wrong-lane wait: only lane1 sends 0xBB at cycle 1 -> valid_out stays 0 and lane_sel stays 0. When lane0 sends 0xAA at cycle 6 -> 0xAA out at cycle 7, 0xBB out at cycle 8.
- Overflow: lane1 pushes 6 words while lane0 stays idle (DEPTH=4) -> overflow_err rises on the 5th push and stays 1. After lane0 supplies 4 words, the output is L0w0,L1w0,...,L0w3,L1w3; lane1 words 5-6 never appear.
- Full FIFO with simultaneous push/pop: fill lane0 to 4 entries, then keep lane0 pushing while lane1 holds data so lane0 gets popped -> no overflow_err, and the order is preserved.
- Async reset mid-stream: assert reset between edges with 3 words buffered -> outputs go to 0 immediately without a clock edge. After release, fresh input C0/C1 yields C0 (from lane 0) first, with no stale words.

Source files
------------

// File: rtl/mux_unstriping.sv
// Two-lane unstriper: per-lane skew FIFOs, read out strictly alternating
// starting at lane 0 so the original word order is restored.
module mux_unstriping #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in0,
    input  logic             valid_in0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic             valid_in1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             overflow_err,
    output logic             lane_sel
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]    wr_ptr_q [2];
    logic [AW-1:0]    wr_ptr_d [2];
    logic [AW-1:0]    rd_ptr_q [2];
    logic [AW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2];
    logic [CW-1:0]    cnt_d    [2];
    logic [WIDTH-1:0] din      [2];
    logic [1:0]       vin;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       drop;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             ovf_q, ovf_d;
    logic             lane_sel_q, lane_sel_d;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign vin    = {valid_in1, valid_in0};

    always_comb begin
        pop         = '0;
        push        = '0;
        drop        = '0;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        lane_sel_d  = lane_sel_q;
        ovf_d       = ovf_q;
        for (int l = 0; l < 2; l++) begin
            wr_ptr_d[l] = wr_ptr_q[l];
            rd_ptr_d[l] = rd_ptr_q[l];
            // Pop decision uses the registered count, so a word pushed this
            // edge is never popped on the same edge.
            pop[l]  = (lane_sel_q == 1'(l)) && (cnt_q[l] != '0);
            push[l] = vin[l] && ((cnt_q[l] != CW'(DEPTH)) || pop[l]);
            drop[l] = vin[l] && (cnt_q[l] == CW'(DEPTH)) && !pop[l];
            if (push[l]) wr_ptr_d[l] = wr_ptr_q[l] + AW'(1);
            if (pop[l])  rd_ptr_d[l] = rd_ptr_q[l] + AW'(1);
            cnt_d[l] = cnt_q[l] + CW'(push[l]) - CW'(pop[l]);
        end
        if (|pop) begin
            data_out_d  = mem_q[lane_sel_q][rd_ptr_q[lane_sel_q]];
            valid_out_d = 1'b1;
            lane_sel_d  = ~lane_sel_q;
        end
        if (|drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_2f) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) mem_q[l][wr_ptr_q[l]] <= din[l];
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            lane_sel_q  <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
            end
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            ovf_q       <= ovf_d;
            lane_sel_q  <= lane_sel_d;
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= wr_ptr_d[l];
                rd_ptr_q[l] <= rd_ptr_d[l];
                cnt_q[l]    <= cnt_d[l];
            end
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign overflow_err = ovf_q;
    assign lane_sel     = lane_sel_q;

endmodule

// File: tb/tb_mux_unstriping.sv
// Directed table-driven bench for mux_unstriping: each row drives one edge and
// checks the registered outputs just after it.
module tb_mux_unstriping;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk_2f = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in0, data_in1;
    logic             valid_in0, valid_in1;
    logic [WIDTH-1:0] data_out;
    logic             valid_out, overflow_err, lane_sel;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             pre_rst;
        logic             v0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [WIDTH-1:0] d1;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic             es;
        logic             eo;
    } vec_t;

    vec_t vecs[$];

    mux_unstriping #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .data_in0    (data_in0),
        .valid_in0   (valid_in0),
        .data_in1    (data_in1),
        .valid_in1   (valid_in1),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .overflow_err(overflow_err),
        .lane_sel    (lane_sel)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pre_rst, input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic ev,
                       input logic [WIDTH-1:0] ed, input logic es, input logic eo);
        vec_t v;
        v.pre_rst = pre_rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.ev = ev; v.ed = ed; v.es = es; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].pre_rst) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
            data_in0  = vecs[i].d0;
            valid_in0 = vecs[i].v0;
            data_in1  = vecs[i].d1;
            valid_in1 = vecs[i].v1;
            @(posedge clk_2f);
            #1;
            chk($sformatf("row%0d valid_out", i), WIDTH'(valid_out), WIDTH'(vecs[i].ev));
            if (vecs[i].ev)
                chk($sformatf("row%0d data_out", i), data_out, vecs[i].ed);
            chk($sformatf("row%0d lane_sel", i), WIDTH'(lane_sel), WIDTH'(vecs[i].es));
            chk($sformatf("row%0d overflow_err", i), WIDTH'(overflow_err), WIDTH'(vecs[i].eo));
        end
    endtask

    initial begin
        int split;
        // Aligned input
        add(0, 1, 32'hA0, 1, 32'hB0, 0, 0,      0, 0);
        add(0, 1, 32'hA1, 1, 32'hB1, 1, 32'hA0, 1, 0);
        add(0, 0, 0,      0, 0,      1, 32'hB0, 0, 0);
        add(0, 0, 0,      0, 0,      1, 32'hA1, 1, 0);
        add(0, 0, 0,      0, 0,      1, 32'hB1, 0, 0);
        add(0, 0, 0,      0, 0,      0, 0,      0, 0);
        // Skew between lanes
        add(0, 1, 32'h11, 0, 0,      0, 0,      0, 0);
        add(0, 0, 0,      0, 0,      1, 32'h11, 1, 0);
        add(0, 0, 0,      0, 0,      0, 0,      1, 0);
        add(0, 0, 0,      1, 32'h22, 0, 0,      1, 0);
        add(0, 0, 0,      0, 0,      1, 32'h22, 0, 0);
        // Lane 1 data while lane 0 is selected and empty: must wait
        add(0, 0, 0,      1, 32'hBB, 0, 0,      0, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 32'hAA, 0, 0,      0, 0,      0, 0);
        add(0, 0, 0,      0, 0,      1, 32'hAA, 1, 0);
        add(0, 0, 0,      0, 0,      1, 32'hBB, 0, 0);
        add(0, 0, 0,      0, 0,      0, 0,      0, 0);
        // Overflow on lane 1; words 5 and 6 are dropped
        for (int k = 0; k < 6; k++)
            add(0, 0, 0, 1, 32'h100 + k, 0, 0, 0, (k >= 4));
        add(0, 1, 32'h200, 0, 0, 0, 0,       0, 1);
        add(0, 1, 32'h201, 0, 0, 1, 32'h200, 1, 1);
        add(0, 1, 32'h202, 0, 0, 1, 32'h100, 0, 1);
        add(0, 1, 32'h203, 0, 0, 1, 32'h201, 1, 1);
        add(0, 0, 0,       0, 0, 1, 32'h101, 0, 1);
        add(0, 0, 0,       0, 0, 1, 32'h202, 1, 1);
        add(0, 0, 0,       0, 0, 1, 32'h102, 0, 1);
        add(0, 0, 0,       0, 0, 1, 32'h203, 1, 1);
        add(0, 0, 0,       0, 0, 1, 32'h103, 0, 1);
        add(0, 0, 0,       0, 0, 0, 0,       0, 1);
        // Full lane 0 with simultaneous push/pop (reset first to clear the flag)
        add(1, 1, 32'h2F0, 0, 0,       0, 0,       0, 0);
        add(0, 0, 0,       0, 0,       1, 32'h2F0, 1, 0);
        add(0, 1, 32'h300, 0, 0,       0, 0,       1, 0);
        add(0, 1, 32'h301, 0, 0,       0, 0,       1, 0);
        add(0, 1, 32'h302, 0, 0,       0, 0,       1, 0);
        add(0, 1, 32'h303, 1, 32'h400, 0, 0,       1, 0);
        add(0, 0, 0,       1, 32'h401, 1, 32'h400, 0, 0);
        add(0, 1, 32'h304, 0, 0,       1, 32'h300, 1, 0);
        add(0, 0, 0,       1, 32'h402, 1, 32'h401, 0, 0);
        add(0, 1, 32'h305, 0, 0,       1, 32'h301, 1, 0);
        add(0, 0, 0,       0, 0,       1, 32'h402, 0, 0);
        add(0, 0, 0,       1, 32'h403, 1, 32'h302, 1, 0);
        add(0, 0, 0,       0, 0,       1, 32'h403, 0, 0);
        add(0, 0, 0,       1, 32'h404, 1, 32'h303, 1, 0);
        split = vecs.size();
        // Fresh traffic after the mid-stream reset; stale words must not appear
        add(0, 1, 32'hC0, 1, 32'hC1, 0, 0,      0, 0);
        add(0, 0, 0,      0, 0,      1, 32'hC0, 1, 0);
        add(0, 0, 0,      0, 0,      1, 32'hC1, 0, 0);
        add(0, 0, 0,      0, 0,      0, 0,      0, 0);

        reset = 1'b1;
        data_in0 = '0; data_in1 = '0; valid_in0 = 1'b0; valid_in1 = 1'b0;
        #12;
        chk("reset data_out", data_out, '0);
        chk("reset valid_out", WIDTH'(valid_out), '0);
        chk("reset overflow_err", WIDTH'(overflow_err), '0);
        chk("reset lane_sel", WIDTH'(lane_sel), '0);
        reset = 1'b0;

        run_rows(0, split);

        // Three words buffered, valid_out high: reset between edges acts at once
        #2;
        reset = 1'b1;
        #1;
        chk("async reset data_out", data_out, '0);
        chk("async reset valid_out", WIDTH'(valid_out), '0);
        chk("async reset lane_sel", WIDTH'(lane_sel), '0);
        chk("async reset overflow_err", WIDTH'(overflow_err), '0);
        #1;
        reset = 1'b0;

        run_rows(split, vecs.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
